dts_format: RTL and testbench



---
 rtl/dts_format.sv | 198 +++++++++++++++++++
 tb/tb_dts_format.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dts_format.sv
// DTS front-end formatter: per-lane frame select/capture, MS-first serialisation
// into OW-bit words, and triplet packing into 8-bit or 3-bit sample words.

module dts_format_lane #(
    parameter int N_INPUTS        = 3,
    parameter int INPUT_WIDTH     = 128,
    parameter int MUX_FACTOR_BITS = 2,
    parameter int SELECT_WIDTH    = 4,
    parameter int OW              = INPUT_WIDTH >> MUX_FACTOR_BITS
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            load,
    input  logic [SELECT_WIDTH-1:0]         sel,
    input  logic [N_INPUTS*INPUT_WIDTH-1:0] din,
    input  logic [N_INPUTS-1:0]             din_locked,
    input  logic [N_INPUTS-1:0]             din_one_sec,
    input  logic [N_INPUTS-1:0]             din_ten_sec,
    input  logic [N_INPUTS-1:0]             din_index,
    input  logic [N_INPUTS-1:0]             din_sync,
    input  logic [MUX_FACTOR_BITS-1:0]      cnt,
    output logic [OW-1:0]                   word,
    output logic                            locked,
    output logic                            one_sec,
    output logic                            ten_sec,
    output logic                            index,
    output logic                            sync
);
    localparam int W = 1 << MUX_FACTOR_BITS;

    // hold[W-1] is the most-significant word, emitted first
    logic [W-1:0][OW-1:0]   hold;
    logic [INPUT_WIDTH-1:0] src;
    logic [4:0]             src_flags;
    logic [4:0]             flags;

    // Out-of-range selects fall through to all-zero frame and flags
    always_comb begin
        src       = '0;
        src_flags = '0;
        for (int j = 0; j < N_INPUTS; j++) begin
            if (int'(sel) == j) begin
                src       = din[j*INPUT_WIDTH +: INPUT_WIDTH];
                src_flags = {din_locked[j], din_one_sec[j], din_ten_sec[j],
                             din_index[j], din_sync[j]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold  <= '0;
            flags <= '0;
        end else if (load) begin
            hold  <= src;
            flags <= src_flags;
        end
    end

    assign word = hold[MUX_FACTOR_BITS'(W - 1) - cnt];
    assign {locked, one_sec, ten_sec, index, sync} = flags;

endmodule

module dts_format #(
    parameter int N_INPUTS        = 3,
    parameter int INPUT_WIDTH     = 128,
    parameter int MUX_FACTOR_BITS = 2,
    parameter int SELECT_WIDTH    = 4
) (
    input  logic                                               clk,
    input  logic                                               rst_n,
    input  logic [N_INPUTS*SELECT_WIDTH-1:0]                   sel,
    input  logic                                               is_three_bit,
    input  logic [N_INPUTS*INPUT_WIDTH-1:0]                    din,
    input  logic                                               din_valid,
    input  logic [N_INPUTS-1:0]                                din_locked,
    input  logic [N_INPUTS-1:0]                                din_one_sec,
    input  logic [N_INPUTS-1:0]                                din_ten_sec,
    input  logic [N_INPUTS-1:0]                                din_index,
    input  logic [N_INPUTS-1:0]                                din_sync,
    output logic [N_INPUTS*(INPUT_WIDTH >> MUX_FACTOR_BITS)-1:0] dout,
    output logic                                               dout_valid,
    output logic [N_INPUTS-1:0]                                dout_locked,
    output logic [N_INPUTS-1:0]                                dout_one_sec,
    output logic [N_INPUTS-1:0]                                dout_ten_sec,
    output logic [N_INPUTS-1:0]                                dout_index,
    output logic [N_INPUTS-1:0]                                dout_sync,
    output logic                                               frame_err
);
    localparam int W  = 1 << MUX_FACTOR_BITS;
    localparam int OW = INPUT_WIDTH >> MUX_FACTOR_BITS;
    localparam int NG = N_INPUTS / 3;

    logic                              busy;
    logic [MUX_FACTOR_BITS-1:0]        cnt;
    logic                              last;
    logic [N_INPUTS-1:0][OW-1:0]       lane_word;
    logic [N_INPUTS-1:0]               lane_locked;
    logic [N_INPUTS-1:0]               lane_one_sec;
    logic [N_INPUTS-1:0]               lane_ten_sec;
    logic [N_INPUTS-1:0]               lane_index;
    logic [N_INPUTS-1:0]               lane_sync;
    logic [N_INPUTS*OW-1:0]            pack_w;

    for (genvar i = 0; i < N_INPUTS; i++) begin : g_lane
        dts_format_lane #(
            .N_INPUTS       (N_INPUTS),
            .INPUT_WIDTH    (INPUT_WIDTH),
            .MUX_FACTOR_BITS(MUX_FACTOR_BITS),
            .SELECT_WIDTH   (SELECT_WIDTH),
            .OW             (OW)
        ) u_lane (
            .clk        (clk),
            .rst_n      (rst_n),
            .load       (din_valid),
            .sel        (sel[i*SELECT_WIDTH +: SELECT_WIDTH]),
            .din        (din),
            .din_locked (din_locked),
            .din_one_sec(din_one_sec),
            .din_ten_sec(din_ten_sec),
            .din_index  (din_index),
            .din_sync   (din_sync),
            .cnt        (cnt),
            .word       (lane_word[i]),
            .locked     (lane_locked[i]),
            .one_sec    (lane_one_sec[i]),
            .ten_sec    (lane_ten_sec[i]),
            .index      (lane_index[i]),
            .sync       (lane_sync[i])
        );
    end

    assign last = (cnt == MUX_FACTOR_BITS'(W - 1));

    // A new frame always wins; it only counts as an error if it cuts a frame short
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            cnt       <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= din_valid && busy && !last;
            if (din_valid) begin
                busy <= 1'b1;
                cnt  <= '0;
            end else if (busy) begin
                cnt <= cnt + 1'b1;
                if (last)
                    busy <= 1'b0;
            end
        end
    end

    // 3-bit mode interleaves bit j of lanes a,b,c into sample j
    always_comb begin
        pack_w = '0;
        for (int g = 0; g < NG; g++) begin
            if (is_three_bit) begin
                for (int j = 0; j < OW; j++)
                    pack_w[g*3*OW + 3*j +: 3] = {lane_word[3*g+2][j], lane_word[3*g+1][j],
                                                 lane_word[3*g][j]};
            end else begin
                pack_w[g*3*OW +: 3*OW] = {lane_word[3*g+2], lane_word[3*g+1], lane_word[3*g]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout         <= '0;
            dout_valid   <= 1'b0;
            dout_locked  <= '0;
            dout_one_sec <= '0;
            dout_ten_sec <= '0;
            dout_index   <= '0;
            dout_sync    <= '0;
        end else begin
            dout_valid <= busy;
            if (busy) begin
                dout        <= pack_w;
                dout_locked <= lane_locked;
            end
            if (busy && cnt == '0) begin
                dout_one_sec <= lane_one_sec;
                dout_ten_sec <= lane_ten_sec;
                dout_index   <= lane_index;
                dout_sync    <= lane_sync;
            end else begin
                dout_one_sec <= '0;
                dout_ten_sec <= '0;
                dout_index   <= '0;
                dout_sync    <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dts_format.sv
// Bench for dts_format: directed cases plus randomized frames checked against a
// queue-of-expected-words reference model.

module tb_dts_format;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [11:0]  sel;
    logic         is_three_bit;
    logic [383:0] din;
    logic         din_valid;
    logic [2:0]   din_locked, din_one_sec, din_ten_sec, din_index, din_sync;
    logic [95:0]  dout;
    logic         dout_valid;
    logic [2:0]   dout_locked, dout_one_sec, dout_ten_sec, dout_index, dout_sync;
    logic         frame_err;

    always #5 clk = ~clk;

    dts_format dut (
        .clk(clk), .rst_n(rst_n), .sel(sel), .is_three_bit(is_three_bit),
        .din(din), .din_valid(din_valid),
        .din_locked(din_locked), .din_one_sec(din_one_sec), .din_ten_sec(din_ten_sec),
        .din_index(din_index), .din_sync(din_sync),
        .dout(dout), .dout_valid(dout_valid),
        .dout_locked(dout_locked), .dout_one_sec(dout_one_sec), .dout_ten_sec(dout_ten_sec),
        .dout_index(dout_index), .dout_sync(dout_sync), .frame_err(frame_err)
    );

    typedef struct {
        logic [2:0][31:0] w;
        logic [2:0]       lk, os, ts, ix, sy;
    } ent_t;

    ent_t        q[$];
    int          checks = 0;
    int          errors = 0;
    logic [95:0] m_dout = '0;
    logic        m_valid = 1'b0;
    logic [2:0]  m_lk = '0;
    logic [11:0] m_pulse = '0;
    logic        m_err = 1'b0;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [31:0] word_of(input logic [127:0] f, input int k);
        logic [127:0] t;
        t = f >> (96 - 32 * k);
        return t[31:0];
    endfunction

    function automatic logic [95:0] pack_exp(input logic [2:0][31:0] w, input logic m);
        logic [95:0] r;
        int s;
        r = '0;
        if (!m) return {w[2], w[1], w[0]};
        for (int j = 0; j < 32; j++) begin
            s = w[0][j] + 2 * w[1][j] + 4 * w[2][j];
            r = r | (96'(s) << (3 * j));
        end
        return r;
    endfunction

    function automatic logic [127:0] byte_frame(input int base);
        logic [127:0] f;
        for (int m = 0; m < 16; m++) f[127 - 8*m -: 8] = 8'(base + 2 * m);
        return f;
    endfunction

    // Model: each sampled frame queues its W output words; one word leaves per edge
    task automatic tick();
        ent_t e;
        int   s;
        if (q.size() > 0) begin
            e = q.pop_front();
            m_valid = 1'b1;
            m_dout  = pack_exp(e.w, is_three_bit);
            m_lk    = e.lk;
            m_pulse = {e.os, e.ts, e.ix, e.sy};
        end else begin
            m_valid = 1'b0;
            m_pulse = '0;
        end
        m_err = 1'b0;
        if (din_valid) begin
            m_err = (q.size() > 0);
            q.delete();
            for (int k = 0; k < 4; k++) begin
                for (int i = 0; i < 3; i++) begin
                    s = int'(sel[i*4 +: 4]);
                    if (s < 3) begin
                        e.w[i]  = word_of(din[s*128 +: 128], k);
                        e.lk[i] = din_locked[s];
                        e.os[i] = (k == 0) & din_one_sec[s];
                        e.ts[i] = (k == 0) & din_ten_sec[s];
                        e.ix[i] = (k == 0) & din_index[s];
                        e.sy[i] = (k == 0) & din_sync[s];
                    end else begin
                        e.w[i] = '0; e.lk[i] = 1'b0; e.os[i] = 1'b0;
                        e.ts[i] = 1'b0; e.ix[i] = 1'b0; e.sy[i] = 1'b0;
                    end
                end
                q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        chk("dout_valid", 128'(dout_valid), 128'(m_valid));
        chk("dout", 128'(dout), 128'(m_dout));
        chk("dout_locked", 128'(dout_locked), 128'(m_lk));
        chk("pulse_flags", 128'({dout_one_sec, dout_ten_sec, dout_index, dout_sync}), 128'(m_pulse));
        chk("frame_err", 128'(frame_err), 128'(m_err));
    endtask

    task automatic load(input logic [127:0] f0, input logic [127:0] f1,
                        input logic [127:0] f2, input logic [11:0] s);
        din = {f2, f1, f0};
        sel = s;
        din_valid = 1'b1;
    endtask

    task automatic set_flags(input logic [14:0] v);
        {din_locked, din_one_sec, din_ten_sec, din_index, din_sync} = v;
    endtask

    task automatic idle_inputs();
        din_valid = 1'b0;
        din = {rnd128(), rnd128(), rnd128()};
        sel = 12'($urandom);
        set_flags(15'($urandom));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_dout"}, 128'(dout), 128'h0);
        chk({tag, "_valid"}, 128'(dout_valid), 128'h0);
        chk({tag, "_flags"}, 128'({dout_locked, dout_one_sec, dout_ten_sec, dout_index, dout_sync}), 128'h0);
        chk({tag, "_err"}, 128'(frame_err), 128'h0);
    endtask

    function automatic logic [11:0] rsel();
        logic [11:0] r;
        int v;
        for (int i = 0; i < 3; i++) begin
            v = $urandom_range(0, 7);
            r[i*4 +: 4] = (v < 6) ? 4'(v % 3) : 4'($urandom_range(3, 15));
        end
        return r;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [127:0] f0;
        int           gap;
        sel = '0; is_three_bit = 1'b0; din = '0; din_valid = 1'b0; set_flags('0);
        #12;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick(); tick();

        // identity select, back-to-back frames, 8-bit mode
        for (int n = 0; n < 3; n++) begin
            load(byte_frame(1 + 32 * n), '0, byte_frame(32 * n), 12'h210);
            set_flags('0);
            tick();
            idle_inputs();
            if (n == 1) chk("id_l0_f0w3", 128'(dout[31:0]), 128'h191B1D1F);
            if (n > 0) chk("id_valid_b2b", 128'(dout_valid), 128'h1);
            for (int k = 1; k < 4; k++) begin
                tick();
                if (n == 0 && k == 1) begin
                    chk("id_l0_w0", 128'(dout[31:0]), 128'h01030507);
                    chk("id_l2_w0", 128'(dout[95:64]), 128'h00020406);
                end
                if (n == 0 && k == 2) chk("id_l0_w1", 128'(dout[31:0]), 128'h090B0D0F);
                if (n == 1 && k == 1) chk("id_l0_f1w0", 128'(dout[31:0]), 128'h21232527);
            end
        end
        repeat (2) tick();

        // reorder
        load(byte_frame(1), '0, byte_frame(0), 12'h012);
        tick(); idle_inputs(); tick();
        chk("ro_l2_w0", 128'(dout[95:64]), 128'h01030507);
        chk("ro_l0_w0", 128'(dout[31:0]), 128'h00020406);
        repeat (4) tick();

        // out-of-range select on lane 1
        load(rnd128(), rnd128(), rnd128(), 12'h2B0);
        set_flags('1);
        tick(); idle_inputs(); tick();
        chk("oor_data", 128'(dout[63:32]), 128'h0);
        chk("oor_flags", 128'({dout_locked[1], dout_one_sec[1], dout_ten_sec[1], dout_index[1], dout_sync[1]}), 128'h0);
        repeat (4) tick();

        // 3-bit packing
        is_three_bit = 1'b1;
        load({32'hFFFF_FFFF, 96'h0}, '0, '0, 12'h210);
        set_flags('0);
        tick(); idle_inputs(); tick();
        chk("3b_lane0", 128'(dout), 128'({8{12'h249}}));
        repeat (4) tick();
        load('0, '0, {32'hFFFF_FFFF, 96'h0}, 12'h210);
        set_flags('0);
        tick(); idle_inputs(); tick();
        chk("3b_lane2", 128'(dout), 128'({8{12'h924}}));
        repeat (4) tick();
        is_three_bit = 1'b0;

        // flag timing
        load(rnd128(), rnd128(), rnd128(), 12'h210);
        set_flags(15'b001_000_000_000_001);
        tick(); idle_inputs();
        tick();
        chk("sync_w0", 128'(dout_sync), 128'h1);
        chk("locked_w0", 128'(dout_locked), 128'h1);
        tick();
        chk("sync_w1", 128'(dout_sync), 128'h0);
        tick(); tick();
        chk("locked_w3", 128'(dout_locked), 128'h1);
        repeat (2) tick();

        // truncation: second din_valid two cycles after the first
        load(rnd128(), rnd128(), rnd128(), 12'h210);
        tick(); idle_inputs(); tick();
        f0 = rnd128();
        load(f0, rnd128(), rnd128(), 12'h210);
        tick();
        chk("trunc_err", 128'(frame_err), 128'h1);
        idle_inputs();
        tick();
        chk("trunc_err_once", 128'(frame_err), 128'h0);
        chk("trunc_new_w0", 128'(dout[31:0]), 128'(f0[127:96]));
        repeat (4) tick();

        // reset mid-frame
        load(rnd128(), rnd128(), rnd128(), 12'h210);
        set_flags('1);
        tick(); idle_inputs(); tick(); tick();
        rst_n = 1'b0;
        #1;
        chk_zero("mid_reset");
        q.delete();
        m_dout = '0;
        m_lk = '0;
        @(posedge clk); @(posedge clk); #1;
        chk_zero("held_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();
        load(rnd128(), rnd128(), rnd128(), 12'h210);
        tick(); idle_inputs();
        repeat (5) tick();

        // randomized frames, gaps (including truncating ones), selects and modes
        for (int it = 0; it < 40; it++) begin
            load(rnd128(), rnd128(), rnd128(), rsel());
            set_flags(15'($urandom));
            gap = $urandom_range(1, 6);
            for (int t = 0; t < gap; t++) begin
                is_three_bit = 1'($urandom);
                tick();
                idle_inputs();
            end
        end
        repeat (6) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
